hazard_ctrl: RTL

Pipeline hazard controller for the 5-stage MIPS core. Sits beside the IF/ID, ID/EX, EX/MEM and MEM/WB buffers and sequences them: it drives the PC and buffer enables, inserts bubbles, flushes on taken branches, stalls for load-use hazards and for the multi-cycle multiply/divide unit (MDU), and produces the EX-stage operand forwarding selects. It also keeps a saturating count of stall cycles for performance analysis.

---
 rtl/hazard_ctrl_pkg.sv | 35 +++
 rtl/hazard_ctrl_if.sv | 48 ++++
 rtl/hazard_ctrl_fwd_unit.sv | 21 ++
 rtl/hazard_ctrl.sv | 122 ++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared widths, FSM encoding and forward-select codes for the hazard controller.
package hazard_ctrl_pkg;

    localparam int unsigned REG_W   = 5;
    localparam int unsigned FWD_W   = 2;
    localparam int unsigned CNT_W   = 4;
    localparam int unsigned STALL_W = 16;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        MDU_BUSY  = 2'd1,
        MDU_DRAIN = 2'd2
    } hc_state_e;

    localparam logic [FWD_W-1:0] FWD_RF  = 2'b00;
    localparam logic [FWD_W-1:0] FWD_MEM = 2'b10;
    localparam logic [FWD_W-1:0] FWD_WB  = 2'b01;

    // Forward select for one EX source; EX/MEM wins over MEM/WB, r0 never forwarded.
    function automatic logic [FWD_W-1:0] fwd_sel(
        input logic [REG_W-1:0] src,
        input logic [REG_W-1:0] dest_mem,
        input logic             we_mem,
        input logic [REG_W-1:0] dest_wb,
        input logic             we_wb
    );
        if (we_mem && (dest_mem != '0) && (dest_mem == src)) begin
            return FWD_MEM;
        end else if (we_wb && (dest_wb != '0) && (dest_wb == src)) begin
            return FWD_WB;
        end
        return FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side signal bundle of the hazard controller.
interface hazard_ctrl_if;
    import hazard_ctrl_pkg::*;

    logic [REG_W-1:0]   rs_ID_HC;
    logic [REG_W-1:0]   rt_ID_HC;
    logic [REG_W-1:0]   rs_EX_HC;
    logic [REG_W-1:0]   rt_EX_HC;
    logic [REG_W-1:0]   dest_EX_HC;
    logic               MemRead_EX_HC;
    logic               RegWrite_EX_HC;
    logic               mdu_start_EX_HC;
    logic               branch_taken_EX_HC;
    logic [REG_W-1:0]   dest_MEM_HC;
    logic               RegWrite_MEM_HC;
    logic [REG_W-1:0]   dest_WB_HC;
    logic               RegWrite_WB_HC;

    logic               pc_en_HC;
    logic               ifid_en_HC;
    logic               idex_en_HC;
    logic               ifid_flush_HC;
    logic               idex_flush_HC;
    logic               exmem_flush_HC;
    logic [FWD_W-1:0]   fwdA_HC;
    logic [FWD_W-1:0]   fwdB_HC;
    logic               mdu_done_HC;
    logic [STALL_W-1:0] stall_cnt_HC;

    // Pipeline datapath side.
    modport master (
        output rs_ID_HC, rt_ID_HC, rs_EX_HC, rt_EX_HC, dest_EX_HC,
               MemRead_EX_HC, RegWrite_EX_HC, mdu_start_EX_HC, branch_taken_EX_HC,
               dest_MEM_HC, RegWrite_MEM_HC, dest_WB_HC, RegWrite_WB_HC,
        input  pc_en_HC, ifid_en_HC, idex_en_HC, ifid_flush_HC, idex_flush_HC,
               exmem_flush_HC, fwdA_HC, fwdB_HC, mdu_done_HC, stall_cnt_HC
    );

    // Hazard controller side.
    modport slave (
        input  rs_ID_HC, rt_ID_HC, rs_EX_HC, rt_EX_HC, dest_EX_HC,
               MemRead_EX_HC, RegWrite_EX_HC, mdu_start_EX_HC, branch_taken_EX_HC,
               dest_MEM_HC, RegWrite_MEM_HC, dest_WB_HC, RegWrite_WB_HC,
        output pc_en_HC, ifid_en_HC, idex_en_HC, ifid_flush_HC, idex_flush_HC,
               exmem_flush_HC, fwdA_HC, fwdB_HC, mdu_done_HC, stall_cnt_HC
    );

endinterface

// File: rtl/hazard_ctrl_fwd_unit.sv
// EX-stage operand forwarding selects; purely combinational.
module hazard_ctrl_fwd_unit
    import hazard_ctrl_pkg::*;
(
    input  logic [REG_W-1:0] rs_EX,
    input  logic [REG_W-1:0] rt_EX,
    input  logic [REG_W-1:0] dest_MEM,
    input  logic             RegWrite_MEM,
    input  logic [REG_W-1:0] dest_WB,
    input  logic             RegWrite_WB,
    output logic [FWD_W-1:0] fwdA,
    output logic [FWD_W-1:0] fwdB
);

    // Independent select for each ALU operand.
    always_comb begin
        fwdA = fwd_sel(rs_EX, dest_MEM, RegWrite_MEM, dest_WB, RegWrite_WB);
        fwdB = fwd_sel(rt_EX, dest_MEM, RegWrite_MEM, dest_WB, RegWrite_WB);
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: enables, bubbles, MDU stall sequencing, forwarding, stall counter.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned MDU_LAT = 4
) (
    input  logic          clk_HC,
    input  logic          rst_n_HC,
    hazard_ctrl_if.slave  hc
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MDU_LAT - 2);

    hc_state_e          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [STALL_W-1:0] stall_cnt_q;
    logic               lu;
    logic               pc_en, ifid_en, idex_en;
    logic               ifid_flush, idex_flush, exmem_flush;
    logic               mdu_done;
    logic [FWD_W-1:0]   fwd_a, fwd_b;

    hazard_ctrl_fwd_unit u_fwd (
        .rs_EX        (hc.rs_EX_HC),
        .rt_EX        (hc.rt_EX_HC),
        .dest_MEM     (hc.dest_MEM_HC),
        .RegWrite_MEM (hc.RegWrite_MEM_HC),
        .dest_WB      (hc.dest_WB_HC),
        .RegWrite_WB  (hc.RegWrite_WB_HC),
        .fwdA         (fwd_a),
        .fwdB         (fwd_b)
    );

    // Load in EX whose destination feeds the instruction in ID.
    assign lu = hc.MemRead_EX_HC && hc.RegWrite_EX_HC && (hc.dest_EX_HC != '0) &&
                ((hc.dest_EX_HC == hc.rs_ID_HC) || (hc.dest_EX_HC == hc.rt_ID_HC));

    // State and MDU down-counter register.
    always_ff @(posedge clk_HC) begin
        if (!rst_n_HC) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state and pipeline control; reset forces all enables and flushes high.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        idex_en     = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        mdu_done    = 1'b0;
        if (!rst_n_HC) begin
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
        end else begin
            unique case (state_q)
                RUN, MDU_DRAIN: begin
                    state_d = RUN;
                    if ((state_q == RUN) && hc.mdu_start_EX_HC) begin
                        pc_en       = 1'b0;
                        ifid_en     = 1'b0;
                        idex_en     = 1'b0;
                        exmem_flush = 1'b1;
                        cnt_d       = CNT_LOAD;
                        state_d     = MDU_BUSY;
                    end else if (hc.branch_taken_EX_HC) begin
                        ifid_flush = 1'b1;
                        idex_flush = 1'b1;
                    end else if (lu) begin
                        pc_en      = 1'b0;
                        ifid_en    = 1'b0;
                        idex_flush = 1'b1;
                    end
                end
                MDU_BUSY: begin
                    pc_en       = 1'b0;
                    ifid_en     = 1'b0;
                    idex_en     = 1'b0;
                    exmem_flush = 1'b1;
                    if (cnt_q == '0) begin
                        mdu_done = 1'b1;
                        state_d  = MDU_DRAIN;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    // Saturating count of cycles with the PC held.
    always_ff @(posedge clk_HC) begin
        if (!rst_n_HC) begin
            stall_cnt_q <= '0;
        end else if (!pc_en && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + STALL_W'(1);
        end
    end

    // Drive the interface; forwarding is held at register-file during reset.
    assign hc.pc_en_HC       = pc_en;
    assign hc.ifid_en_HC     = ifid_en;
    assign hc.idex_en_HC     = idex_en;
    assign hc.ifid_flush_HC  = ifid_flush;
    assign hc.idex_flush_HC  = idex_flush;
    assign hc.exmem_flush_HC = exmem_flush;
    assign hc.mdu_done_HC    = mdu_done;
    assign hc.fwdA_HC        = rst_n_HC ? fwd_a : FWD_RF;
    assign hc.fwdB_HC        = rst_n_HC ? fwd_b : FWD_RF;
    assign hc.stall_cnt_HC   = stall_cnt_q;

endmodule
